// File: rtl/atm_cash_unit_if.sv
// rtl/atm_cash_unit_if.sv - strobe, dispenser and status bundle of the ATM cash unit
//
// Purpose : groups the controller strobes, the dispenser handshake and the
//           status/counter outputs of atm_cash_unit into one port.
// Signals : W_50000/W_100000/W_200000  withdraw 1/2/4 units (level strobes)
//           D_50000/D_100000/D_200000  deposit 1/2/4 units (level strobes)
//           note_ready                 dispenser can accept a note
//           note_out                   one-cycle pulse per dispensed note
//           busy, done                 transaction in progress / finished
//           err_funds, err_cash,
//           err_limit                  error flags, valid with done
//           err_cmd                    several strobes rose together
//           balance, notes             current balance and cassette count
// Modports: master = controller/dispenser side, slave = cash unit side.
interface atm_cash_unit_if #(
  parameter int BAL_W  = 24,
  parameter int CASS_W = 8
);
  logic              W_50000;
  logic              W_100000;
  logic              W_200000;
  logic              D_50000;
  logic              D_100000;
  logic              D_200000;
  logic              note_ready;
  logic              note_out;
  logic              busy;
  logic              done;
  logic              err_funds;
  logic              err_cash;
  logic              err_cmd;
  logic              err_limit;
  logic [BAL_W-1:0]  balance;
  logic [CASS_W-1:0] notes;

  modport master (
    output W_50000, W_100000, W_200000, D_50000, D_100000, D_200000, note_ready,
    input  note_out, busy, done, err_funds, err_cash, err_cmd, err_limit,
           balance, notes
  );

  modport slave (
    input  W_50000, W_100000, W_200000, D_50000, D_100000, D_200000, note_ready,
    output note_out, busy, done, err_funds, err_cash, err_cmd, err_limit,
           balance, notes
  );
endinterface

// File: rtl/atm_cash_unit.sv
// rtl/atm_cash_unit.sv - ATM cash back end: balance, cassette and note metering
//
// Purpose : turns the controller's one-hot withdraw/deposit strobes into
//           balance and cassette updates, meters withdrawn notes one at a
//           time to the dispenser and reports completion/error status.
// Ports   : clock  system clock, all state updates on posedge
//           reset  asynchronous active-low reset
//           bus    atm_cash_unit_if.slave (strobes, note_ready/note_out,
//                  busy/done/err_*, balance, notes)
// Options : ATM_DAILY_LIMIT_EN adds a withdrawn-total counter and the
//           err_limit check against DAILY_LIMIT; otherwise err_limit is 0.
module atm_cash_unit #(
  parameter int BAL_W       = 24,
  parameter int CASS_W      = 8,
  parameter int INIT_BAL    = 40,
  parameter int INIT_NOTES  = 100,
  parameter int NOTE_GAP    = 2,
  parameter int DAILY_LIMIT = 20
) (
  input logic           clock,
  input logic           reset,
  atm_cash_unit_if.slave bus
);

  localparam int              GAP_W    = (NOTE_GAP > 1) ? $clog2(NOTE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(NOTE_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_RDY,
    PULSE,
    GAP,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [5:0]        strobes;
  logic [5:0]        prev_q;
  logic [5:0]        rise;
  logic              single_rise;
  logic              multi_rise;
  logic [2:0]        dec_units;
  logic              dec_wd;

  logic [2:0]        units_q;
  logic              wd_q;
  logic [2:0]        remaining_q;
  logic [GAP_W-1:0]  gap_q;
  logic [BAL_W-1:0]  balance_q;
  logic [CASS_W-1:0] notes_q;
  logic              err_funds_q;
  logic              err_cash_q;
  logic              err_limit_q;
  logic              err_cmd_q;

  logic [BAL_W-1:0]  units_bal;
  logic [CASS_W-1:0] units_cass;
  logic [BAL_W:0]    bal_sum;
  logic [CASS_W:0]   notes_sum;
  logic              funds_short;
  logic              cash_short;
  logic              limit_hit;
  logic              withdraw_ok;

  // Bit order: [0..2] withdraw 1/2/4 units, [3..5] deposit 1/2/4 units.
  assign strobes = {bus.D_200000, bus.D_100000, bus.D_50000,
                    bus.W_200000, bus.W_100000, bus.W_50000};
  assign rise        = strobes & ~prev_q;
  // rise & (rise - 1) clears the lowest set bit: non-zero means 2+ rises.
  assign multi_rise  = (rise & (rise - 6'd1)) != 6'd0;
  assign single_rise = (rise != 6'd0) && !multi_rise;

  always_comb begin
    dec_wd    = |rise[2:0];
    dec_units = 3'd4;
    if (rise[0] || rise[3]) begin
      dec_units = 3'd1;
    end else if (rise[1] || rise[4]) begin
      dec_units = 3'd2;
    end
  end

  assign units_bal   = {{(BAL_W-3){1'b0}}, units_q};
  assign units_cass  = {{(CASS_W-3){1'b0}}, units_q};
  assign bal_sum     = {1'b0, balance_q} + {1'b0, units_bal};
  assign notes_sum   = {1'b0, notes_q} + {1'b0, units_cass};
  assign funds_short = balance_q < units_bal;
  assign cash_short  = notes_q < units_cass;
  assign withdraw_ok = !funds_short && !cash_short && !limit_hit;

`ifdef ATM_DAILY_LIMIT_EN
  logic [31:0] total_q;

  assign limit_hit = (total_q + {29'd0, units_q}) > 32'(DAILY_LIMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      total_q <= 32'd0;
    end else if (state_q == CHECK && wd_q && withdraw_ok) begin
      total_q <= total_q + {29'd0, units_q};
    end
  end
`else
  logic [31:0] unused_daily_limit;

  assign limit_hit          = 1'b0;
  assign unused_daily_limit = 32'(DAILY_LIMIT);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (single_rise) state_d = CHECK;
      CHECK:    state_d = (wd_q && withdraw_ok) ? WAIT_RDY : DONE;
      WAIT_RDY: if (bus.note_ready) state_d = PULSE;
      PULSE:    state_d = (remaining_q == 3'd1) ? DONE : GAP;
      // On the last gap cycle a ready dispenser goes straight to PULSE, so
      // consecutive notes are exactly NOTE_GAP idle cycles apart.
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = bus.note_ready ? PULSE : WAIT_RDY;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q      <= 6'd0;
      units_q     <= 3'd0;
      wd_q        <= 1'b0;
      remaining_q <= 3'd0;
      gap_q       <= '0;
      balance_q   <= BAL_W'(INIT_BAL);
      notes_q     <= CASS_W'(INIT_NOTES);
      err_funds_q <= 1'b0;
      err_cash_q  <= 1'b0;
      err_limit_q <= 1'b0;
      err_cmd_q   <= 1'b0;
    end else begin
      prev_q    <= strobes;
      err_cmd_q <= (state_q == IDLE) && multi_rise;
      case (state_q)
        IDLE: begin
          if (single_rise) begin
            units_q <= dec_units;
            wd_q    <= dec_wd;
          end
        end
        CHECK: begin
          if (!wd_q) begin
            balance_q <= bal_sum[BAL_W] ? '1 : bal_sum[BAL_W-1:0];
            notes_q   <= notes_sum[CASS_W] ? '1 : notes_sum[CASS_W-1:0];
          end else if (withdraw_ok) begin
            // Debit up front; a reset mid-dispense restores INIT_BAL anyway.
            balance_q   <= balance_q - units_bal;
            notes_q     <= notes_q - units_cass;
            remaining_q <= units_q;
          end else begin
            err_funds_q <= funds_short;
            err_cash_q  <= !funds_short && cash_short;
            err_limit_q <= !funds_short && !cash_short && limit_hit;
          end
        end
        PULSE: begin
          remaining_q <= remaining_q - 3'd1;
          gap_q       <= '0;
        end
        GAP: begin
          gap_q <= gap_q + 1'b1;
        end
        DONE: begin
          err_funds_q <= 1'b0;
          err_cash_q  <= 1'b0;
          err_limit_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.note_out  = (state_q == PULSE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err_funds = err_funds_q;
  assign bus.err_cash  = err_cash_q;
  assign bus.err_limit = err_limit_q;
  assign bus.err_cmd   = err_cmd_q;
  assign bus.balance   = balance_q;
  assign bus.notes     = notes_q;

endmodule

// File: tb/tb_atm_cash_unit.sv
// tb/tb_atm_cash_unit.sv - self-checking bench for atm_cash_unit
module tb_atm_cash_unit;

  localparam int BAL_W     = 24;
  localparam int CASS_W    = 8;
  localparam int LIMIT     = 5;
  localparam int BAL_MAX   = (1 << BAL_W) - 1;
  localparam int NOTES_MAX = (1 << CASS_W) - 1;
`ifdef ATM_DAILY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference state: balance/cassette/withdrawn total as plain integers.
  int m_bal, m_notes, m_total;

  always #5 clock = ~clock;

  atm_cash_unit_if #(.BAL_W(BAL_W), .CASS_W(CASS_W)) bus0 ();
  atm_cash_unit_if #(.BAL_W(BAL_W), .CASS_W(CASS_W)) bus1 ();

  atm_cash_unit #(.BAL_W(BAL_W), .CASS_W(CASS_W), .INIT_BAL(40), .INIT_NOTES(100),
                  .NOTE_GAP(2), .DAILY_LIMIT(LIMIT))
    dut0 (.clock(clock), .reset(reset), .bus(bus0));

  atm_cash_unit #(.BAL_W(BAL_W), .CASS_W(CASS_W), .INIT_BAL(1), .INIT_NOTES(0),
                  .NOTE_GAP(2), .DAILY_LIMIT(LIMIT))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  task automatic drive0(input logic [5:0] s);
    {bus0.D_200000, bus0.D_100000, bus0.D_50000,
     bus0.W_200000, bus0.W_100000, bus0.W_50000} = s;
  endtask

  task automatic drive1(input logic [5:0] s);
    {bus1.D_200000, bus1.D_100000, bus1.D_50000,
     bus1.W_200000, bus1.W_100000, bus1.W_50000} = s;
  endtask

  // code 0..2 = withdraw 1/2/4 units, 3..5 = deposit 1/2/4 units
  task automatic model_apply(input int code, output bit ef, output bit ec,
                             output bit el, output int np);
    int u;
    u = (code % 3 == 0) ? 1 : (code % 3 == 1) ? 2 : 4;
    ef = 0; ec = 0; el = 0; np = 0;
    if (code >= 3) begin
      m_bal   = (m_bal + u > BAL_MAX) ? BAL_MAX : m_bal + u;
      m_notes = (m_notes + u > NOTES_MAX) ? NOTES_MAX : m_notes + u;
    end else if (m_bal < u) begin
      ef = 1;
    end else if (m_notes < u) begin
      ec = 1;
    end else if (LIMIT_EN && (m_total + u > LIMIT)) begin
      el = 1;
    end else begin
      m_bal   -= u;
      m_notes -= u;
      m_total += u;
      np = u;
    end
  endtask

  task automatic model_reset();
    m_bal = 40; m_notes = 100; m_total = 0;
  endtask

  task automatic apply_reset();
    drive0(6'd0);
    drive1(6'd0);
    bus0.note_ready = 1'b0;
    bus1.note_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
  endtask

  // Drives one strobe pattern on dut0 (starting at a negedge) and observes
  // until the transaction has completed and the strobe has been released.
  task automatic run_txn(input logic [5:0] s, input int hold, input bit rnd_ready,
                         output int pulses, output int dones, output int first_pulse,
                         output int min_gap, output int done_at, output bit ef,
                         output bit ec, output bit el, output int stray, output bit tmo);
    int c;
    int last_p;
    pulses = 0; dones = 0; first_pulse = -1; min_gap = 1000; done_at = -1;
    ef = 0; ec = 0; el = 0; stray = 0; tmo = 1; last_p = -1; c = 0;
    bus0.note_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    drive0(s);
    while (c < 400) begin
      c++;
      @(negedge clock);
      if (bus0.note_out) begin
        pulses++;
        if (first_pulse < 0) first_pulse = c;
        else if (c - last_p < min_gap) min_gap = c - last_p;
        last_p = c;
      end
      if (bus0.done) begin
        dones++;
        done_at = c;
        ef |= bus0.err_funds;
        ec |= bus0.err_cash;
        el |= bus0.err_limit;
      end
      if (!bus0.done && (bus0.err_funds || bus0.err_cash || bus0.err_limit)) stray++;
      if (bus0.err_cmd) stray++;
      if (c == hold) drive0(6'd0);
      if (rnd_ready) bus0.note_ready = ($urandom_range(0, 3) != 0);
      if (c >= hold + 2 && dones > 0 && !bus0.busy) begin
        tmo = 0;
        break;
      end
    end
    drive0(6'd0);
  endtask

  task automatic test_reset();
    drive0(6'd0);
    drive1(6'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (bus0.balance !== 24'd40) begin
      errors++; $display("FAIL reset_balance got=%0d exp=40", bus0.balance);
    end
    checks++;
    if (bus0.notes !== 8'd100) begin
      errors++; $display("FAIL reset_notes got=%0d exp=100", bus0.notes);
    end
    checks++;
    if ({bus0.busy, bus0.done, bus0.note_out, bus0.err_funds, bus0.err_cash,
         bus0.err_cmd, bus0.err_limit} !== 7'd0) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000000",
        {bus0.busy, bus0.done, bus0.note_out, bus0.err_funds, bus0.err_cash,
         bus0.err_cmd, bus0.err_limit});
    end
    checks++;
    if ({bus1.balance, bus1.notes} !== {24'd1, 8'd0}) begin
      errors++; $display("FAIL reset_dut1 got=%0d/%0d exp=1/0", bus1.balance, bus1.notes);
    end
    apply_reset();
    checks++;
    if (bus0.busy !== 1'b0 || bus0.balance !== 24'd40) begin
      errors++; $display("FAIL post_reset_idle busy=%b bal=%0d exp busy=0 bal=40",
                         bus0.busy, bus0.balance);
    end
  endtask

  task automatic test_withdraw();
    int p, d, fp, mg, da, st, np; bit ef, ec, el, to, xf, xc, xl;
    model_apply(1, xf, xc, xl, np);
    run_txn(6'b000010, 1, 1'b0, p, d, fp, mg, da, ef, ec, el, st, to);
    checks++;
    if (to) begin errors++; $display("FAIL wd_timeout got=timeout exp=done"); end
    checks++;
    if (p !== np) begin errors++; $display("FAIL wd_pulses got=%0d exp=%0d", p, np); end
    checks++;
    if (mg !== 3) begin errors++; $display("FAIL wd_pulse_spacing got=%0d exp=3", mg); end
    checks++;
    if (fp !== 3) begin errors++; $display("FAIL wd_first_note got=%0d exp=3", fp); end
    checks++;
    if ({d, ef, ec, el, st} !== {32'd1, xf, xc, xl, 32'd0}) begin
      errors++; $display("FAIL wd_status got=d%0d %b%b%b st%0d exp=d1 %b%b%b st0",
                         d, ef, ec, el, st, xf, xc, xl);
    end
    checks++;
    if (bus0.balance !== BAL_W'(m_bal) || bus0.notes !== CASS_W'(m_notes)) begin
      errors++; $display("FAIL wd_counts got=%0d/%0d exp=%0d/%0d",
                         bus0.balance, bus0.notes, m_bal, m_notes);
    end
  endtask

  task automatic test_deposit();
    int p, d, fp, mg, da, st, np; bit ef, ec, el, to, xf, xc, xl;
    model_apply(5, xf, xc, xl, np);
    run_txn(6'b100000, 1, 1'b0, p, d, fp, mg, da, ef, ec, el, st, to);
    checks++;
    if (to || da !== 2) begin
      errors++; $display("FAIL dep_latency got=%0d exp=2", da);
    end
    checks++;
    if (p !== 0 || d !== 1 || {ef, ec, el} !== 3'b000) begin
      errors++; $display("FAIL dep_status got=p%0d d%0d %b%b%b exp=p0 d1 000", p, d, ef, ec, el);
    end
    checks++;
    if (bus0.balance !== BAL_W'(m_bal) || bus0.notes !== CASS_W'(m_notes)) begin
      errors++; $display("FAIL dep_counts got=%0d/%0d exp=%0d/%0d",
                         bus0.balance, bus0.notes, m_bal, m_notes);
    end
  endtask

  // dut1 starts with balance 1 and an empty cassette.
  task automatic test_errors();
    logic [5:0] pat [2];
    logic [1:0] exp_err [2];
    pat[0] = 6'b000010; exp_err[0] = 2'b10;
    pat[1] = 6'b000001; exp_err[1] = 2'b01;
    for (int t = 0; t < 2; t++) begin
      int dn, pl; logic [1:0] fl;
      dn = 0; pl = 0; fl = 2'b00;
      @(negedge clock);
      drive1(pat[t]);
      for (int c = 0; c < 8; c++) begin
        @(negedge clock);
        if (bus1.note_out) pl++;
        if (bus1.done) begin dn++; fl = {bus1.err_funds, bus1.err_cash}; end
      end
      drive1(6'd0);
      checks++;
      if (dn !== 1 || fl !== exp_err[t]) begin
        errors++; $display("FAIL err_flags_%0d got=d%0d %b exp=d1 %b", t, dn, fl, exp_err[t]);
      end
      checks++;
      if (pl !== 0 || bus1.balance !== 24'd1 || bus1.notes !== 8'd0) begin
        errors++; $display("FAIL err_nochange_%0d got=p%0d %0d/%0d exp=p0 1/0",
                           t, pl, bus1.balance, bus1.notes);
      end
    end
  endtask

  task automatic test_hold_and_cmd();
    int p, d, fp, mg, da, st, np, cm, cmd_at, bz; bit ef, ec, el, to, xf, xc, xl;
    model_apply(0, xf, xc, xl, np);
    run_txn(6'b000001, 10, 1'b0, p, d, fp, mg, da, ef, ec, el, st, to);
    checks++;
    if (to || p !== np || d !== 1) begin
      errors++; $display("FAIL hold_once got=p%0d d%0d exp=p%0d d1", p, d, np);
    end
    cm = 0; cmd_at = -1; bz = 0;
    drive0(6'b001001);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (bus0.err_cmd) begin cm++; cmd_at = c; end
      if (bus0.busy) bz++;
    end
    drive0(6'd0);
    checks++;
    if (cm !== 1 || cmd_at !== 1 || bz !== 0) begin
      errors++; $display("FAIL err_cmd got=n%0d at%0d busy%0d exp=n1 at1 busy0", cm, cmd_at, bz);
    end
    checks++;
    if (bus0.balance !== BAL_W'(m_bal) || bus0.notes !== CASS_W'(m_notes)) begin
      errors++; $display("FAIL cmd_counts got=%0d/%0d exp=%0d/%0d",
                         bus0.balance, bus0.notes, m_bal, m_notes);
    end
    @(negedge clock);
  endtask

  task automatic test_limit();
    apply_reset();
    for (int t = 0; t < 2; t++) begin
      int p, d, fp, mg, da, st, np; bit ef, ec, el, to, xf, xc, xl;
      model_apply(2, xf, xc, xl, np);
      run_txn(6'b000100, 1, 1'b0, p, d, fp, mg, da, ef, ec, el, st, to);
      checks++;
      if (to || p !== np || el !== xl || ef !== xf || ec !== xc) begin
        errors++; $display("FAIL limit_%0d got=p%0d lim%b exp=p%0d lim%b", t, p, el, np, xl);
      end
      checks++;
      if (bus0.balance !== BAL_W'(m_bal)) begin
        errors++; $display("FAIL limit_bal_%0d got=%0d exp=%0d", t, bus0.balance, m_bal);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      int p, d, fp, mg, da, st, np, code; bit ef, ec, el, to, xf, xc, xl;
      code = $urandom_range(0, 5);
      model_apply(code, xf, xc, xl, np);
      run_txn(6'(1 << code), $urandom_range(1, 6), 1'b1, p, d, fp, mg, da, ef, ec, el, st, to);
      checks++;
      if (to || p !== np || d !== 1 || {ef, ec, el} !== {xf, xc, xl} || st !== 0) begin
        errors++; $display("FAIL rnd_%0d code%0d got=p%0d d%0d %b%b%b st%0d exp=p%0d d1 %b%b%b st0",
                           t, code, p, d, ef, ec, el, st, np, xf, xc, xl);
      end
      checks++;
      if (np > 1 && mg < 3) begin
        errors++; $display("FAIL rnd_gap_%0d got=%0d exp>=3", t, mg);
      end
      checks++;
      if (bus0.balance !== BAL_W'(m_bal) || bus0.notes !== CASS_W'(m_notes)) begin
        errors++; $display("FAIL rnd_counts_%0d got=%0d/%0d exp=%0d/%0d",
                           t, bus0.balance, bus0.notes, m_bal, m_notes);
      end
    end
  endtask

  task automatic test_stall_reset();
    int bz, pl, c; bit got2;
    apply_reset();
    bz = 0; pl = 0; got2 = 0;
    bus0.note_ready = 1'b0;
    drive0(6'b000100);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus0.busy) bz++;
      if (bus0.note_out) pl++;
    end
    checks++;
    if (bz !== 20 || pl !== 0) begin
      errors++; $display("FAIL stall got=busy%0d notes%0d exp=busy20 notes0", bz, pl);
    end
    bus0.note_ready = 1'b1;
    c = 0;
    while (c < 40 && !got2) begin
      c++;
      @(negedge clock);
      if (bus0.note_out) pl++;
      if (pl == 2) got2 = 1;
    end
    checks++;
    if (!got2) begin errors++; $display("FAIL stall_second_note got=%0d exp=2", pl); end
    reset = 1'b0;
    drive0(6'd0);
    #1;
    pl = 0; bz = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus0.note_out) pl++;
      if (bus0.busy) bz++;
    end
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus0.note_out) pl++;
      if (bus0.busy) bz++;
    end
    checks++;
    if (pl !== 0 || bz !== 0) begin
      errors++; $display("FAIL abort got=notes%0d busy%0d exp=0/0", pl, bz);
    end
    checks++;
    if (bus0.balance !== BAL_W'(m_bal) || bus0.notes !== CASS_W'(m_notes)) begin
      errors++; $display("FAIL abort_counts got=%0d/%0d exp=%0d/%0d",
                         bus0.balance, bus0.notes, m_bal, m_notes);
    end
  endtask

  initial begin
    bus0.note_ready = 1'b0;
    bus1.note_ready = 1'b1;
    model_reset();
    test_reset();
    test_withdraw();
    test_deposit();
    test_errors();
    test_hold_and_cmd();
    test_limit();
    test_random();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atm_cash_unit.md
Name: atm_cash_unit

Overview:
- Cash-handling back end that consumes the ATM controller's one-hot transaction strobes: W_50000, W_100000, W_200000, D_50000, D_100000, D_200000.
- Maintains the account balance and a single 50000-note cassette count.
- Meters withdrawn notes one at a time to the dispenser mechanism through a ready/pulse handshake.
- Reports completion and error status back to the controller.

Parameters:
BAL_W, 24, balance width in 50000 units
CASS_W, 8, cassette note-count width
INIT_BAL, 40, balance after reset (units of 50000)
INIT_NOTES, 100, cassette count after reset
NOTE_GAP, 2, idle cycles between consecutive note_out pulses (>=1)
DAILY_LIMIT, 20, max withdrawn units since reset (ATM_DAILY_LIMIT_EN only)

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous active-low reset
W_50000  in  1  withdraw 1 unit request (level; acted on at its rising edge)
W_100000  in  1  withdraw 2 units
W_200000  in  1  withdraw 4 units
D_50000  in  1  deposit 1 unit
D_100000  in  1  deposit 2 units
D_200000  in  1  deposit 4 units
note_ready  in  1  dispenser can accept a note
note_out  out  1  one-cycle pulse per note dispensed
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at transaction end (success or error)
err_funds  out  1  pulse with done: balance < request
err_cash  out  1  pulse with done: cassette < request
err_cmd  out  1  one-cycle pulse: more than one strobe rose in the same cycle
err_limit  out  1  pulse with done: daily limit exceeded
balance  out  BAL_W  current balance (units)
notes  out  CASS_W  current cassette count

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - balance=INIT_BAL, notes=INIT_NOTES.
  - All pulse outputs and busy are 0; the edge-detect register is cleared.
  - Reset mid-dispense aborts immediately; no further note_out; balance is restored to INIT_BAL.
- Edge detect:
  - prev register samples all six strobes every cycle.
  - rise = strobe & ~prev.
  - A strobe held high starts exactly one transaction.
- IDLE:
  - Exactly one rise: latch units (1/2/4) and direction, go to CHECK.
  - More than one rise: err_cmd pulses next cycle; stay in IDLE.
  - Rises outside IDLE are ignored and not queued.
- busy = (state != IDLE).
- CHECK (one cycle):
  - Deposit: balance += units and notes += units, each saturating at all-ones; go to DONE.
  - Withdraw, balance < units: set err_funds; go to DONE.
  - Withdraw, otherwise notes < units: set err_cash; go to DONE.
  - Withdraw, otherwise: debit balance and notes by units, remaining = units; go to WAIT_RDY.
  - err_funds takes priority over err_cash.
- WAIT_RDY: go to PULSE when note_ready=1; wait indefinitely otherwise.
- PULSE: note_out=1 for this cycle only; remaining -= 1.
  - remaining was 1: go to DONE.
  - Otherwise: go to GAP.
- GAP: count NOTE_GAP cycles, then go to WAIT_RDY.
- DONE (one cycle):
  - done=1, plus latched error flag(s).
  - Error flags clear, return to IDLE.
- Latency:
  - Rise sampled at edge k → CHECK in cycle k+1.
  - Deposit done in cycle k+2.
  - First note_out no earlier than cycle k+2.
- All outputs are registered or decoded from state only (Moore). No combinational path from inputs to outputs.

Optional Feature:
ATM_DAILY_LIMIT_EN:
- Defined:
  - A withdrawn-total counter, reset to 0, accumulates successful withdrawals.
  - In CHECK, after the funds and cash checks pass: if total + units > DAILY_LIMIT, set err_limit, debit nothing, go to DONE.
- Undefined:
  - No counter is built and DAILY_LIMIT is unused.
  - err_limit is tied 0.

Test Plan:
1. reset=0 then release → balance=40, notes=100; busy, done, note_out and all errors 0.
2. W_100000 rises with note_ready=1, NOTE_GAP=2 → busy; two note_out pulses 3 cycles apart; done; balance=38, notes=98, no errors.
3. D_200000 rises → done 2 cycles after the rise; balance=44, notes=104; no note_out.
4. INIT_BAL=1, W_100000 → err_funds and done in the same cycle; balance=1, notes unchanged; no note_out. INIT_NOTES=1, INIT_BAL=40, W_200000 → err_cash.
5. W_50000 held high 10 cycles → exactly one note_out and one done. D_50000 and W_50000 rise together → err_cmd pulse, no state change.
6. note_ready=0 during W_200000 → stays busy in WAIT_RDY. Assert reset after the 2nd note_out → note_out stays 0, balance=40, busy=0. With ATM_DAILY_LIMIT_EN and DAILY_LIMIT=5: two W_200000 → second gives err_limit with balance unchanged.
